// File: rtl/gcd_pkg.sv
// Shared types for the gcd request client: FSM state encoding and the request record.
// Combinational definitions only; no latency, no backpressure of its own.
package gcd_pkg;

    localparam int GCD_XLEN    = 32;
    localparam int GCD_TAG_W   = 4;
    localparam int GCD_DEPTH   = 4;
    localparam int GCD_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } gcd_client_state_e;

    typedef struct packed {
        logic [GCD_XLEN-1:0]  a;
        logic [GCD_XLEN-1:0]  b;
        logic [GCD_TAG_W-1:0] tag;
    } gcd_req_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Request FIFO for gcd_client; a push is visible at the head one cycle later.
// Pushes are dropped while full and pops while empty; no write-through when full.
module gcd_req_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // The extra top bit tells a full ring apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/gcd_client.sv
// Tagged request initiator for the gcd engine: one load in flight, zero operands answered locally, hung engine timed out.
// Pop-to-load 1 cycle, engine valid to response 1 cycle; req stalls when the FIFO is full, response is held until rsp_ready_i.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int XLEN    = GCD_XLEN,
    parameter int DEPTH   = GCD_DEPTH,
    parameter int TAG_W   = GCD_TAG_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_gcd_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             gcd_ld_o,
    output logic [XLEN-1:0]  gcd_a_o,
    output logic [XLEN-1:0]  gcd_b_o,
    input  logic             gcd_ready_i,
    input  logic             gcd_valid_i,
    input  logic [XLEN-1:0]  gcd_res_i,
    output logic             busy_o
);

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
    } req_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIM_ONE = TW'(1);

    gcd_client_state_e state, state_nxt;

    req_t             push_dat;
    req_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             head_zero;
    logic             timer_first;
    logic             timer_done;
    logic [TW-1:0]    timer;
    logic [XLEN-1:0]  work_a;
    logic [XLEN-1:0]  work_b;
    logic [TAG_W-1:0] work_tag;
    logic [XLEN-1:0]  res;
    logic             err;

    assign push_dat    = {req_a_i, req_b_i, req_tag_i};
    assign req_ready_o = !fifo_full;
    assign head_zero   = (head.a == '0) || (head.b == '0);
    assign timer_first = (timer == '0);
    assign timer_done  = (timer == TMAX);

    gcd_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (req_valid_i),
        .push_dat (push_dat),
        .pop_rdy  (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = head_zero ? RESP : ISSUE;
            ISSUE: if (gcd_ready_i) state_nxt = WAIT;
            // Valid in the first WAIT cycle is the engine's stale result from before the load.
            WAIT:  if ((gcd_valid_i && !timer_first) || timer_done) state_nxt = RESP;
            RESP:  if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = (state == IDLE) && !fifo_empty;
        gcd_ld_o    = (state == ISSUE) && gcd_ready_i;
        gcd_a_o     = gcd_ld_o ? work_a : '0;
        gcd_b_o     = gcd_ld_o ? work_b : '0;
        rsp_valid_o = (state == RESP);
        busy_o      = (state != IDLE) || !fifo_empty;
    end

    assign rsp_gcd_o = res;
    assign rsp_tag_o = work_tag;
    assign rsp_err_o = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_a   <= '0;
            work_b   <= '0;
            work_tag <= '0;
            res      <= '0;
            err      <= 1'b0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        work_a   <= head.a;
                        work_b   <= head.b;
                        work_tag <= head.tag;
                        if (head_zero) begin
                            res <= head.a | head.b;
                            err <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (gcd_ready_i) timer <= '0;
                end
                WAIT: begin
                    if (timer != '1) timer <= timer + TIM_ONE;
                    if (gcd_valid_i && !timer_first) begin
                        res <= gcd_res_i;
                        err <= 1'b0;
                    end else if (timer_done) begin
                        res <= '0;
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
